// File: rtl/button_event_fsm.sv
// Debounced push-button level to clk-domain event pulses (press, release,
// long-press, auto-repeat) with a wrapping press counter.
module button_event_fsm #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn_in,
  input  logic             en,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD, WAIT_REL} state_t;

  state_t           state, state_nxt;
  logic             btn_p0, btn_p1;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [RW-1:0]    rep_cnt, rep_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;

  // Counters stop at their threshold so they can never wrap back into range.
  function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] c);
    return (c == HOLD_LAST) ? c : c + HW'(1);
  endfunction

  function automatic logic [RW-1:0] rep_inc(input logic [RW-1:0] c);
    return (c == REP_LAST) ? c : c + RW'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser, btn_p1 is the clk-domain level
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_in;
      btn_p1 <= btn_p0;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    rep_nxt     = rep_cnt;
    cnt_nxt     = press_count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    if (!en) begin
      // Parking in WAIT_REL while pressed forces a fresh release/press cycle.
      state_nxt = btn_p1 ? WAIT_REL : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (btn_p1) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
            cnt_nxt   = press_count + CNT_W'(1);
            hold_nxt  = '0;
          end
        end
        PRESSED: begin
          hold_nxt = hold_inc(hold_cnt);
          if (!btn_p1) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt = LONG_HELD;
            long_nxt  = 1'b1;
            rep_nxt   = '0;
          end
        end
        LONG_HELD: begin
          rep_nxt = rep_inc(rep_cnt);
          if (!btn_p1) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (rep_cnt == REP_LAST) begin
            repeat_nxt = 1'b1;
            rep_nxt    = '0;
          end
        end
        WAIT_REL: begin
          if (!btn_p1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD);
  end

  // Stage p2: FSM state, counters and registered event outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_count   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      rep_cnt       <= rep_nxt;
      press_count   <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      held          <= held_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Scoreboard bench for button_event_fsm: stimulus queues expected events,
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_button_event_fsm;

  localparam int LC = 10;
  localparam int RC = 4;
  localparam int CW = 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic        hld;
    logic [CW-1:0] cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          clr, btn_in, en;
  logic          press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [CW-1:0] press_count;

  ev_t           q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_cnt;

  button_event_fsm #(
    .LONG_CYCLES  (LC),
    .REPEAT_CYCLES(RC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .btn_in       (btn_in),
    .en           (en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic h);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.hld  = h;
    e.cnt  = exp_cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_step();
    logic [3:0] p;
    int         k;
    ev_t        e;
    if (clr) return;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event: kind %0d not seen, expected at cycle %0d", e.kind, e.cyc);
    end
    p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
    if (p != 4'b0000) begin
      chk("pulse_onehot", $countones(p), 1);
      k = press_pulse ? K_PRESS : release_pulse ? K_REL : long_pulse ? K_LONG : K_REP;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_kind", k, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_held", int'(held), int'(e.hld));
        chk("ev_count", int'(press_count), int'(e.cnt));
      end
    end
  endtask

  // Press now for h cycles; a press driven after edge d shows up in cycle d+3.
  task automatic do_press(input int h);
    int p;
    p = cyc + 3;
    exp_cnt = exp_cnt + 1'b1;
    push(K_PRESS, p, 1'b1);
    if (h > LC) begin
      push(K_LONG, p + LC, 1'b1);
      for (int t = p + LC + RC; t < p + h; t += RC) push(K_REP, t, 1'b1);
    end
    push(K_REL, p + h, 1'b0);
    btn_in = 1'b1;
    repeat (h) tick();
    btn_in = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int p;
    clr     = 1'b1;
    btn_in  = 1'b0;
    en      = 1'b1;
    exp_cnt = '0;
    fork
      forever @(negedge clk) mon_step();
    join_none

    repeat (3) tick();
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_release", int'(release_pulse), 0);
    chk("rst_long", int'(long_pulse), 0);
    chk("rst_repeat", int'(repeat_pulse), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_count", int'(press_count), 0);
    clr = 1'b0;
    tick();

    // short press, long hold with repeats, release on the long threshold
    do_press(5);
    chk("t1_count", int'(press_count), 1);
    do_press(30);
    do_press(10);
    chk("t3_count", int'(press_count), 3);

    // en dropped in LONG_HELD, re-enabled while still pressed
    p = cyc + 3;
    exp_cnt = exp_cnt + 1'b1;
    push(K_PRESS, p, 1'b1);
    push(K_LONG, p + LC, 1'b1);
    btn_in = 1'b1;
    repeat (15) tick();
    en = 1'b0;
    tick();
    chk("t4_held_en_off", int'(held), 0);
    repeat (5) tick();
    en = 1'b1;
    repeat (6) tick();
    chk("t4_held_en_back", int'(held), 0);
    chk("t4_count_no_press", int'(press_count), int'(exp_cnt));
    btn_in = 1'b0;
    repeat (6) tick();
    do_press(3);
    chk("t4_count_resumed", int'(press_count), 5);

    // clear between presses, then counter wrap
    clr = 1'b1;
    #1;
    chk("t5_clr_count", int'(press_count), 0);
    tick();
    clr = 1'b0;
    exp_cnt = '0;
    tick();
    for (int i = 0; i < 17; i++) do_press(2);
    chk("t5_wrap_count", int'(press_count), 1);

    // clear in the middle of a hold, button kept down through it
    p = cyc + 3;
    exp_cnt = exp_cnt + 1'b1;
    push(K_PRESS, p, 1'b1);
    btn_in = 1'b1;
    repeat (6) tick();
    chk("t5_held_before_clr", int'(held), 1);
    #2;
    clr = 1'b1;
    #1;
    chk("t5_async_held", int'(held), 0);
    chk("t5_async_count", int'(press_count), 0);
    chk("t5_async_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    exp_cnt = '0;
    repeat (2) tick();
    clr = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    push(K_PRESS, cyc + 3, 1'b1);
    repeat (8) tick();
    chk("t5_held_after_clr", int'(held), 1);
    push(K_REL, cyc + 3, 1'b0);
    btn_in = 1'b0;
    repeat (6) tick();
    chk("t5_final_count", int'(press_count), 1);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
